// File: rtl/led_ui_pkg.sv
// Shared definitions for the button/LED user interface blocks.
// Default blink timings are in clk30 cycles.
package led_ui_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } blink_state_t;

    localparam int CLK30_FREQ  = 30000000;
    localparam int ON_CYC_DEF  = CLK30_FREQ / 5;   // 200 ms lit
    localparam int OFF_CYC_DEF = CLK30_FREQ / 5;   // 200 ms dark between blinks
    localparam int GAP_CYC_DEF = CLK30_FREQ;       // 1 s dark after the last blink

endpackage

// File: rtl/blink_timer.sv
// Up-counting cycle timer with synchronous clear.
// tc flags the last cycle of a limit-cycle interval (count == limit-1).
module blink_timer #(
    parameter int TMR_W = 32
) (
    input  logic             clk30,
    input  logic             rst,
    input  logic             clr,
    input  logic [TMR_W-1:0] limit,
    output logic             tc
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk30 or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else
            count <= count + TMR_W'(1);
    end

    assign tc = (count == limit - TMR_W'(1));

endmodule

// File: rtl/led_blink_encoder.sv
// Shows an accepted count as N blinks on one LED, followed by a dark gap.
// Only one count is handled at a time; in_ready is high only in IDLE.
//
// state | meaning
// IDLE  | waiting for a count, LED dark
// ON    | LED lit for ON_CYC cycles
// OFF   | LED dark for OFF_CYC cycles between blinks
// GAP   | LED dark for GAP_CYC cycles; done on the last one
module led_blink_encoder
    import led_ui_pkg::*;
#(
    parameter int COUNT_W = 7,
    parameter int ON_CYC  = ON_CYC_DEF,
    parameter int OFF_CYC = OFF_CYC_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF,
    parameter int TMR_W   = 32
) (
    input  logic               clk30,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COUNT_W-1:0] in_count,
    output logic               blink_out,
    output logic               busy,
    output logic               done
);

    blink_state_t       state;
    logic [COUNT_W-1:0] remaining;
    logic [TMR_W-1:0]   limit;
    logic               tmr_clr;
    logic               tmr_tc;

    always_comb begin
        limit = TMR_W'(ON_CYC);
        case (state)
            OFF:     limit = TMR_W'(OFF_CYC);
            GAP:     limit = TMR_W'(GAP_CYC);
            default: limit = TMR_W'(ON_CYC);
        endcase
    end

    // Every terminal count in ON/OFF/GAP leaves the state, so tc doubles as the
    // state-change strobe; holding the timer clear in IDLE makes each new state start at 0.
    assign tmr_clr = (state == IDLE) || tmr_tc;

    blink_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk30 (clk30),
        .rst   (rst),
        .clr   (tmr_clr),
        .limit (limit),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clk30 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            blink_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_count != '0) begin
                            remaining <= in_count;
                            blink_out <= 1'b1;
                            state     <= ON;
                        end else begin
                            state     <= GAP;
                        end
                    end
                end
                ON: begin
                    if (tmr_tc) begin
                        remaining <= remaining - COUNT_W'(1);
                        blink_out <= 1'b0;
                        state     <= (remaining == COUNT_W'(1)) ? GAP : OFF;
                    end
                end
                OFF: begin
                    if (tmr_tc) begin
                        blink_out <= 1'b1;
                        state     <= ON;
                    end
                end
                GAP: begin
                    if (tmr_tc)
                        state <= IDLE;
                end
                default: begin
                    blink_out <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign done     = (state == GAP) && tmr_tc;

endmodule

// File: tb/tb_led_blink_encoder.sv
// Directed bench for led_blink_encoder with short timings (ON=3, OFF=2, GAP=5)
// plus a second instance at ON=OFF=GAP=1 for the maximum count.
module tb_led_blink_encoder;

    logic       clk30 = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, blink_out, busy, done;
    logic [6:0] in_count;
    logic       in_valid2, in_ready2, blink2, busy2, done2;
    logic [6:0] in_count2;

    int checks   = 0;
    int failures = 0;

    always #5 clk30 = ~clk30;

    led_blink_encoder #(
        .COUNT_W (7), .ON_CYC (3), .OFF_CYC (2), .GAP_CYC (5), .TMR_W (8)
    ) dut (
        .clk30     (clk30),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_count  (in_count),
        .blink_out (blink_out),
        .busy      (busy),
        .done      (done)
    );

    led_blink_encoder #(
        .COUNT_W (7), .ON_CYC (1), .OFF_CYC (1), .GAP_CYC (1), .TMR_W (8)
    ) dut_fast (
        .clk30     (clk30),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_count  (in_count2),
        .blink_out (blink2),
        .busy      (busy2),
        .done      (done2)
    );

    // Called at a negedge; returns #1 after the accept edge (cycle 0).
    task automatic present(input logic [6:0] c);
        in_valid = 1'b1;
        in_count = c;
        @(posedge clk30);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] obs, exp;
        rst = 1'b1;
        in_valid = 1'b0; in_count = '0;
        in_valid2 = 1'b0; in_count2 = '0;
        exp = 4'b0001;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk30);
            if (k == 2) rst = 1'b0;
            obs = {blink_out, busy, done, in_ready};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset step %0d: {blink,busy,done,ready} got %b expected %b", k, obs, exp);
            end
            obs = {blink2, busy2, done2, in_ready2};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_fast step %0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_count3;
        logic [3:0] obs, exp;
        logic       eb;
        present(7'd3);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk30);
            eb  = (k >= 1 && k <= 3) || (k >= 6 && k <= 8) || (k >= 11 && k <= 13);
            exp = {eb, k <= 18, k == 18, k >= 19};
            obs = {blink_out, busy, done, in_ready};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL count3 cycle %0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_zero;
        logic [3:0] obs, exp;
        present(7'd0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk30);
            exp = {1'b0, k <= 5, k == 5, k >= 6};
            obs = {blink_out, busy, done, in_ready};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL count0 cycle %0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] obs, exp;
        logic       eb, eby, prev;
        int         rises;
        prev  = 1'b0;
        rises = 0;
        in_valid = 1'b1;
        in_count = 7'd1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk30);
            eb  = (k >= 1 && k <= 3) || (k >= 10 && k <= 12) || (k >= 15 && k <= 17);
            eby = (k >= 1 && k <= 8) || (k >= 10 && k <= 22);
            exp = {eb, eby, k == 8 || k == 22, !eby};
            obs = {blink_out, busy, done, in_ready};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", k, obs, exp);
            end
            if (blink_out && !prev) rises++;
            prev = blink_out;
            if (k == 2)  in_count = 7'd2;
            if (k == 10) in_valid = 1'b0;
        end
        checks++;
        if (rises !== 3) begin
            failures++;
            $display("FAIL back_to_back rises: got %0d expected 3", rises);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] obs, exp;
        present(7'd5);
        @(negedge clk30);
        @(negedge clk30);
        checks++;
        if (blink_out !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid pre-reset blink: got %b expected 1", blink_out);
        end
        #2 rst = 1'b1;
        #1;
        obs = {blink_out, busy, done, in_ready};
        checks++;
        if (obs !== 4'b0001) begin
            failures++;
            $display("FAIL reset_mid async: got %b expected 0001", obs);
        end
        @(negedge clk30);
        @(negedge clk30);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk30);
            obs = {blink_out, busy, done, in_ready};
            checks++;
            if (obs !== 4'b0001) begin
                failures++;
                $display("FAIL reset_mid idle %0d: got %b expected 0001", k, obs);
            end
        end
        present(7'd1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk30);
            exp = {k <= 3, k <= 8, k == 8, k >= 9};
            obs = {blink_out, busy, done, in_ready};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_mid recount cycle %0d: got %b expected %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_max127;
        int   rises, busy_cnt, done_cnt, done_at;
        logic prev;
        rises = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
        prev = 1'b0;
        in_valid2 = 1'b1;
        in_count2 = 7'd127;
        @(posedge clk30);
        #1 in_valid2 = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk30);
            if (blink2 && !prev) rises++;
            prev = blink2;
            if (busy2) busy_cnt++;
            if (done2) begin
                done_cnt++;
                done_at = k;
            end
        end
        checks++;
        if (rises !== 127) begin
            failures++;
            $display("FAIL max127 rises: got %0d expected 127", rises);
        end
        checks++;
        if (busy_cnt !== 254) begin
            failures++;
            $display("FAIL max127 busy cycles: got %0d expected 254", busy_cnt);
        end
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL max127 done pulses: got %0d expected 1", done_cnt);
        end
        checks++;
        if (done_at !== 254) begin
            failures++;
            $display("FAIL max127 done cycle: got %0d expected 254", done_at);
        end
    endtask

    initial begin
        test_reset();
        test_count3();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_max127();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_blink_encoder.md
Name: led_blink_encoder

Overview:
- Transmit side of the button/LED user interface: takes a 7-bit count over a valid/ready handshake and shows it as N visible blinks on one LED, then a fixed dark gap.
- Sits beside the press-counting input logic. Its output drives one LED pin directly, or one bit of the LED bus.
- Single clock domain: clk30 (30 MHz).

Parameters:
- COUNT_W, 7, width of the count input.
- ON_CYC, 6000000, cycles the LED stays lit per blink (200 ms at 30 MHz); must be ≥1.
- OFF_CYC, 6000000, dark cycles between consecutive blinks; must be ≥1.
- GAP_CYC, 30000000, dark cycles after the last blink before the block is ready again; must be ≥1.
- TMR_W, 32, timer width; must hold max(ON_CYC, OFF_CYC, GAP_CYC).

Ports:
- clk30  in  1  system clock, 30 MHz
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  in_count is valid
- in_ready  out  1  block can accept a count; high only in IDLE
- in_count  in  COUNT_W  number of blinks to emit, 0..2^COUNT_W-1
- blink_out  out  1  registered LED drive, 1 = lit
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse on the final GAP cycle

Behaviour:
- Interface (already decided): reset rst, asynchronous, active-high; clock clk30.
- Reset, asynchronous and immediate, including mid-sequence:
  - state = IDLE; blink_out = 0, done = 0, busy = 0, in_ready = 1.
  - Timer and remaining-count registers cleared.
  - Any sequence in progress is abandoned and not resumed.
- States: IDLE, ON, OFF, GAP.
- Accept: on a rising edge of clk30 where in_valid && in_ready.
  - If in_count ≠ 0: load remaining = in_count, timer = 0, go to ON.
  - If in_count = 0: go straight to GAP.
  - in_valid while not in IDLE is ignored; no queuing. The source holds in_valid until in_ready.
- ON:
  - blink_out = 1. It is high from the cycle after acceptance: latency 1 cycle.
  - Lasts exactly ON_CYC cycles.
  - On exit, decrement remaining. If remaining was 1, go to GAP; otherwise go to OFF.
- OFF: blink_out = 0 for exactly OFF_CYC cycles, then ON.
- GAP:
  - blink_out = 0 for exactly GAP_CYC cycles.
  - done = 1 during the last GAP cycle; IDLE follows.
- Timer:
  - Counts 0..X-1 within each state and resets to 0 on every state change.
  - Compares are against X-1 with no off-by-one: a state with duration X occupies exactly X clock cycles.
- Total busy cycles for count N:
  - N ≥ 1: N·ON_CYC + (N-1)·OFF_CYC + GAP_CYC.
  - N = 0: GAP_CYC.
- Back-to-back: a count presented with in_valid held high is accepted on the first IDLE cycle after done. Minimum dead time is 1 IDLE cycle.
- Max count (127) must not overflow remaining; no wrap-around.
- All outputs are registered or decoded from the state register only; no combinational path from in_valid/in_count to any output.
- Unknown or illegal state encoding → IDLE on the next cycle.

Decomposition:
- Shared package led_ui_pkg holds:
  - the state enum (IDLE/ON/OFF/GAP);
  - CLK30_FREQ = 30000000;
  - default blink-timing constants in cycles.
- One natural sub-module, blink_timer: TMR_W-bit cycle counter with clear and terminal-count output (tc when count == limit-1).
- The FSM and remaining-count register stay in led_blink_encoder.

Test Plan:
All scenarios use ON_CYC=3, OFF_CYC=2, GAP_CYC=5; cycle 0 is the accept edge.
- Reset/idle: assert rst for 3 cycles, then release → blink_out=0, busy=0, done=0, in_ready=1 throughout.
- count=3 → blink_out high cycles 1-3, 6-8, 11-13 and low 4-5, 9-10, 14-18; done=1 only at cycle 18; in_ready=1 at cycle 19; busy high cycles 1-18.
- count=0 → blink_out stays 0; busy cycles 1-5; done at cycle 5; in_ready at 6.
- count=1 with in_valid held high and in_count changed to 2 at cycle 2 → second value accepted at cycle 9 (first IDLE after done at 8); two blinks follow; first value not re-sent.
- Reset mid-ON of count=5, asserted at cycle 2 → blink_out=0 and in_ready=1 on the same cycle asynchronously; no done pulse; a new count=1 after release blinks exactly once.
- count=127 with ON=OFF=1, GAP=1 → exactly 127 rising edges on blink_out; busy length 127+126+1 = 254 cycles; single done pulse.
